// File: rtl/exmem_pipe_reg_if.sv
// EX/MEM stage bundle: the EX-side fields going in and the registered MEM-side fields coming out.
// The master drives the In* fields; the slave (the pipeline register) drives the registered copies.
interface exmem_pipe_reg_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               InValid;
  logic [XLEN-1:0]    InALUOUT;
  logic [XLEN-1:0]    InPC;
  logic [XLEN-1:0]    InStoreData;
  logic               InDmemREB;
  logic               InDmemWEB;
  logic [RADDR_W-1:0] InEXMEMrd;
  logic               InRegWE;

  logic               Valid;
  logic [XLEN-1:0]    ALUOUT;
  logic [XLEN-1:0]    PC;
  logic [XLEN-1:0]    StoreData;
  logic               DmemREB;
  logic               DmemWEB;
  logic [RADDR_W-1:0] EXMEMrd;
  logic               RegWE;

  modport master (
    output InValid, InALUOUT, InPC, InStoreData, InDmemREB, InDmemWEB, InEXMEMrd, InRegWE,
    input  Valid, ALUOUT, PC, StoreData, DmemREB, DmemWEB, EXMEMrd, RegWE
  );

  modport slave (
    input  InValid, InALUOUT, InPC, InStoreData, InDmemREB, InDmemWEB, InEXMEMrd, InRegWE,
    output Valid, ALUOUT, PC, StoreData, DmemREB, DmemWEB, EXMEMrd, RegWE
  );
endinterface

// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid bit, stall/flush, bubble-safe strobe gating and a saturating stall counter.
// Define EXMEM_FWD_EN to add the IDEXrs1/IDEXrs2 inputs and FwdA/FwdB rd-match forwarding flags.
module exmem_pipe_reg #(
  parameter int XLEN       = 32,
  parameter int RADDR_W    = 5,
  parameter int STALLCNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  exmem_pipe_reg_if.slave       bus,
  input  logic                  Stall,
  input  logic                  Flush,
  output logic [STALLCNT_W-1:0] StallCycles
`ifdef EXMEM_FWD_EN
  ,
  input  logic [RADDR_W-1:0]    IDEXrs1,
  input  logic [RADDR_W-1:0]    IDEXrs2,
  output logic                  FwdA,
  output logic                  FwdB
`endif
);

  localparam logic [STALLCNT_W-1:0] StallMax = {STALLCNT_W{1'b1}};
  localparam logic [STALLCNT_W-1:0] StallOne = {{(STALLCNT_W-1){1'b0}}, 1'b1};

  // Flush beats Stall beats load; strobes are gated on the way in so a bubble is always inert.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      bus.Valid     <= 1'b0;
      bus.ALUOUT    <= {XLEN{1'b0}};
      bus.PC        <= {XLEN{1'b0}};
      bus.StoreData <= {XLEN{1'b0}};
      bus.DmemREB   <= 1'b1;
      bus.DmemWEB   <= 1'b1;
      bus.EXMEMrd   <= {RADDR_W{1'b0}};
      bus.RegWE     <= 1'b0;
      StallCycles   <= {STALLCNT_W{1'b0}};
    end else if (Flush) begin
      bus.Valid     <= 1'b0;
      bus.ALUOUT    <= {XLEN{1'b0}};
      bus.PC        <= {XLEN{1'b0}};
      bus.StoreData <= {XLEN{1'b0}};
      bus.DmemREB   <= 1'b1;
      bus.DmemWEB   <= 1'b1;
      bus.EXMEMrd   <= {RADDR_W{1'b0}};
      bus.RegWE     <= 1'b0;
    end else if (Stall) begin
      if (bus.Valid && (StallCycles != StallMax)) begin
        StallCycles <= StallCycles + StallOne;
      end
    end else begin
      bus.Valid     <= bus.InValid;
      bus.ALUOUT    <= bus.InALUOUT;
      bus.PC        <= bus.InPC;
      bus.StoreData <= bus.InStoreData;
      bus.DmemREB   <= bus.InDmemREB | ~bus.InValid;
      bus.DmemWEB   <= bus.InDmemWEB | ~bus.InValid;
      bus.EXMEMrd   <= bus.InEXMEMrd;
      bus.RegWE     <= bus.InRegWE & bus.InValid & (bus.InEXMEMrd != {RADDR_W{1'b0}});
    end
  end

`ifdef EXMEM_FWD_EN
  // RegWE is already zero for rd=0, so no separate x0 guard is needed here.
  assign FwdA = bus.RegWE & bus.Valid & (bus.EXMEMrd == IDEXrs1);
  assign FwdB = bus.RegWE & bus.Valid & (bus.EXMEMrd == IDEXrs2);
`endif

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Directed self-checking bench for exmem_pipe_reg (STALLCNT_W=4 so saturation is reachable).
// Forwarding checks are compiled only when EXMEM_FWD_EN is defined.
module tb_exmem_pipe_reg;

  logic       CLK;
  logic       RSTN;
  logic       Stall;
  logic       Flush;
  logic [3:0] StallCycles;
  int         compared;
  int         mismatched;

  exmem_pipe_reg_if #(.XLEN(32), .RADDR_W(5)) bus ();

`ifdef EXMEM_FWD_EN
  logic [4:0] IDEXrs1;
  logic [4:0] IDEXrs2;
  logic       FwdA;
  logic       FwdB;
`endif

  exmem_pipe_reg #(.XLEN(32), .RADDR_W(5), .STALLCNT_W(4)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .bus        (bus.slave),
    .Stall      (Stall),
    .Flush      (Flush),
    .StallCycles(StallCycles)
`ifdef EXMEM_FWD_EN
    ,
    .IDEXrs1    (IDEXrs1),
    .IDEXrs2    (IDEXrs2),
    .FwdA       (FwdA),
    .FwdB       (FwdB)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Both active-low strobes asserted together is an illegal instruction encoding.
  always @(posedge CLK) begin
    if (RSTN) begin
      assert (!(bus.InDmemREB == 1'b0 && bus.InDmemWEB == 1'b0))
        else $error("[TB] illegal InDmemREB=0 with InDmemWEB=0");
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] pc,
                               input logic [31:0] sd, input logic reb, input logic web,
                               input logic [4:0] rd, input logic we, input logic st, input logic fl);
    @(negedge CLK);
    bus.InValid     = v;
    bus.InALUOUT    = alu;
    bus.InPC        = pc;
    bus.InStoreData = sd;
    bus.InDmemREB   = reb;
    bus.InDmemWEB   = web;
    bus.InEXMEMrd   = rd;
    bus.InRegWE     = we;
    Stall           = st;
    Flush           = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 32'hCAFE_0001, 32'h0000_0040, 32'h1111_2222, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    compared++;
    if (bus.Valid !== 1'b1 || bus.DmemREB !== 1'b0 || bus.RegWE !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL preload: Valid/REB/RegWE=%b%b%b expected 101", bus.Valid, bus.DmemREB, bus.RegWE);
    end
    @(negedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    compared++;
    if (bus.Valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.Valid); end
    compared++;
    if (bus.ALUOUT !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_aluout: got %h expected 0", bus.ALUOUT); end
    compared++;
    if (bus.PC !== 32'h0 || bus.StoreData !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rst_pc_sd: got %h/%h expected 0/0", bus.PC, bus.StoreData);
    end
    compared++;
    if (bus.EXMEMrd !== 5'd0 || bus.RegWE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_rd_we: got %0d/%b expected 0/0", bus.EXMEMrd, bus.RegWE);
    end
    compared++;
    if (bus.DmemREB !== 1'b1 || bus.DmemWEB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_strobes: got %b%b expected 11", bus.DmemREB, bus.DmemWEB);
    end
    compared++;
    if (StallCycles !== 4'd0) begin mismatched++; $display("[TB] FAIL rst_stallcnt: got %0d expected 0", StallCycles); end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_load();
    applyStimulus(1'b1, 32'h0000_1234, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    compared++;
    if (bus.ALUOUT !== 32'h0000_1234) begin mismatched++; $display("[TB] FAIL load_alu: got %h expected 00001234", bus.ALUOUT); end
    compared++;
    if (bus.PC !== 32'h0000_0100 || bus.StoreData !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("[TB] FAIL load_pc_sd: got %h/%h expected 00000100/deadbeef", bus.PC, bus.StoreData);
    end
    compared++;
    if (bus.EXMEMrd !== 5'd5 || bus.RegWE !== 1'b1 || bus.Valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL load_rd_we_v: got %0d/%b/%b expected 5/1/1", bus.EXMEMrd, bus.RegWE, bus.Valid);
    end
    compared++;
    if (bus.DmemREB !== 1'b1 || bus.DmemWEB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL load_strobes: got %b%b expected 11", bus.DmemREB, bus.DmemWEB);
    end
  endtask

  task automatic test_stall_flush();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h9999_9999, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
      tick();
      compared++;
      if (bus.ALUOUT !== 32'h0000_1234 || bus.Valid !== 1'b1 || bus.EXMEMrd !== 5'd5 || bus.DmemWEB !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL stall_hold%0d: got alu=%h v=%b rd=%0d web=%b expected 00001234/1/5/1",
                 i, bus.ALUOUT, bus.Valid, bus.EXMEMrd, bus.DmemWEB);
      end
    end
    compared++;
    if (StallCycles !== 4'd3) begin mismatched++; $display("[TB] FAIL stall_count: got %0d expected 3", StallCycles); end
    applyStimulus(1'b1, 32'h7777_7777, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1);
    tick();
    compared++;
    if (bus.Valid !== 1'b0 || bus.RegWE !== 1'b0 || bus.DmemWEB !== 1'b1 || bus.DmemREB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_ctrl: got v=%b we=%b reb=%b web=%b expected 0/0/1/1",
               bus.Valid, bus.RegWE, bus.DmemREB, bus.DmemWEB);
    end
    compared++;
    if (bus.ALUOUT !== 32'h0 || bus.PC !== 32'h0 || bus.EXMEMrd !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL flush_data: got %h/%h/%0d expected 0/0/0", bus.ALUOUT, bus.PC, bus.EXMEMrd);
    end
    compared++;
    if (StallCycles !== 4'd3) begin mismatched++; $display("[TB] FAIL flush_count: got %0d expected 3", StallCycles); end
    applyStimulus(1'b1, 32'h5555_5555, 32'h0, 32'h0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    compared++;
    if (StallCycles !== 4'd3 || bus.Valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bubble_stall: got cnt=%0d v=%b expected 3/0", StallCycles, bus.Valid);
    end
  endtask

  task automatic test_bubble_gating();
    applyStimulus(1'b0, 32'h0000_00AA, 32'h0000_0400, 32'h0000_00BB, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    compared++;
    if (bus.DmemWEB !== 1'b1 || bus.RegWE !== 1'b0 || bus.Valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bubble_gate: got web=%b we=%b v=%b expected 1/0/0", bus.DmemWEB, bus.RegWE, bus.Valid);
    end
    compared++;
    if (bus.EXMEMrd !== 5'd9 || bus.ALUOUT !== 32'h0000_00AA) begin
      mismatched++;
      $display("[TB] FAIL bubble_data: got %0d/%h expected 9/000000aa", bus.EXMEMrd, bus.ALUOUT);
    end
    applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0404, 32'h0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    compared++;
    if (bus.RegWE !== 1'b0 || bus.Valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rd0_gate: got we=%b v=%b expected 0/1", bus.RegWE, bus.Valid);
    end
    applyStimulus(1'b1, 32'h0000_2000, 32'h0000_0408, 32'h0BAD_F00D, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    compared++;
    if (bus.DmemWEB !== 1'b0 || bus.DmemREB !== 1'b1 || bus.StoreData !== 32'h0BAD_F00D || bus.RegWE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL store_pass: got web=%b reb=%b sd=%h we=%b expected 0/1/0badf00d/0",
               bus.DmemWEB, bus.DmemREB, bus.StoreData, bus.RegWE);
    end
    applyStimulus(1'b1, 32'h0000_3000, 32'h0000_040C, 32'h0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    compared++;
    if (bus.DmemREB !== 1'b0 || bus.DmemWEB !== 1'b1 || bus.RegWE !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL load_pass: got reb=%b web=%b we=%b expected 0/1/1", bus.DmemREB, bus.DmemWEB, bus.RegWE);
    end
  endtask

  task automatic test_saturation();
    applyStimulus(1'b1, 32'h0000_4444, 32'h0000_0500, 32'h0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) begin
        compared++;
        if (StallCycles !== 4'd13) begin mismatched++; $display("[TB] FAIL sat_mid: got %0d expected 13", StallCycles); end
      end
    end
    compared++;
    if (StallCycles !== 4'd15) begin mismatched++; $display("[TB] FAIL sat_final: got %0d expected 15", StallCycles); end
    compared++;
    if (bus.ALUOUT !== 32'h0000_3000 || bus.EXMEMrd !== 5'd6) begin
      mismatched++;
      $display("[TB] FAIL sat_hold: got %h/%0d expected 00003000/6", bus.ALUOUT, bus.EXMEMrd);
    end
    Stall = 1'b0;
  endtask

`ifdef EXMEM_FWD_EN
  task automatic test_forwarding();
    applyStimulus(1'b1, 32'h0000_0777, 32'h0000_0600, 32'h0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    IDEXrs1 = 5'd0;
    IDEXrs2 = 5'd0;
    tick();
    IDEXrs1 = 5'd7;
    IDEXrs2 = 5'd3;
    #1;
    compared++;
    if (FwdA !== 1'b1 || FwdB !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fwd_rs1: got %b%b expected 10", FwdA, FwdB);
    end
    IDEXrs1 = 5'd2;
    IDEXrs2 = 5'd7;
    #1;
    compared++;
    if (FwdA !== 1'b0 || FwdB !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL fwd_rs2: got %b%b expected 01", FwdA, FwdB);
    end
    applyStimulus(1'b1, 32'h0, 32'h0000_0604, 32'h0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    IDEXrs1 = 5'd0;
    IDEXrs2 = 5'd0;
    tick();
    compared++;
    if (FwdA !== 1'b0 || FwdB !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fwd_rd0: got %b%b expected 00", FwdA, FwdB);
    end
    applyStimulus(1'b0, 32'h0, 32'h0000_0608, 32'h0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    IDEXrs1 = 5'd7;
    tick();
    compared++;
    if (FwdA !== 1'b0) begin mismatched++; $display("[TB] FAIL fwd_bubble: got %b expected 0", FwdA); end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    RSTN       = 1'b0;
    Stall      = 1'b0;
    Flush      = 1'b0;
    bus.InValid     = 1'b0;
    bus.InALUOUT    = 32'h0;
    bus.InPC        = 32'h0;
    bus.InStoreData = 32'h0;
    bus.InDmemREB   = 1'b1;
    bus.InDmemWEB   = 1'b1;
    bus.InEXMEMrd   = 5'd0;
    bus.InRegWE     = 1'b0;
`ifdef EXMEM_FWD_EN
    IDEXrs1 = 5'd0;
    IDEXrs2 = 5'd0;
`endif
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;

    test_reset();
    test_load();
    test_stall_flush();
    test_bubble_gating();
    test_saturation();
`ifdef EXMEM_FWD_EN
    test_forwarding();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
